ulpi_link: RTL and testbench



---
 rtl/ulpi_link_if.sv | 31 +++
 rtl/ulpi_link.sv | 179 +++++++++++++++++
 tb/tb_ulpi_link.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_link_if.sv
// System-side bundle of ulpi_link: register request/response and RX stream.
interface ulpi_link_if;
  logic [7:0] sys_reg_addr;
  logic [7:0] sys_reg_wdata;
  logic       sys_reg_write;
  logic       sys_reg_read;
  logic       sys_reg_busy;
  logic [7:0] sys_reg_rdata;
  logic       sys_reg_done;
  logic       sys_reg_err;
  logic [7:0] sys_data;
  logic       sys_data_valid;
  logic [7:0] sys_rx_cmd;
  logic       sys_rx_cmd_valid;
  logic       sys_rx_active;
  logic       sys_rx_end;

  modport master (
    output sys_reg_addr, sys_reg_wdata, sys_reg_write, sys_reg_read,
    input  sys_reg_busy, sys_reg_rdata, sys_reg_done, sys_reg_err,
           sys_data, sys_data_valid, sys_rx_cmd, sys_rx_cmd_valid,
           sys_rx_active, sys_rx_end
  );

  modport slave (
    input  sys_reg_addr, sys_reg_wdata, sys_reg_write, sys_reg_read,
    output sys_reg_busy, sys_reg_rdata, sys_reg_done, sys_reg_err,
           sys_data, sys_data_valid, sys_rx_cmd, sys_rx_cmd_valid,
           sys_rx_active, sys_rx_end
  );
endinterface

// File: rtl/ulpi_link.sv
// Link-side ULPI controller: register access engine with stp/timeout,
// RX packet framing and abort reporting, all in the ulpi_clk domain.
module ulpi_link #(
  parameter int EXT_REG_EN = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic       ulpi_clk,
  input  logic       sys_reset,
  input  logic       ulpi_dir,
  input  logic       ulpi_nxt,
  output logic       ulpi_stp,
  inout  wire  [7:0] ulpi_data,
  ulpi_link_if.slave sys
);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] EXT   = 3'd2;
  localparam logic [2:0] WDATA = 3'd3;
  localparam logic [2:0] STP   = 3'd4;
  localparam logic [2:0] RTURN = 3'd5;
  localparam logic [2:0] RDATA = 3'd6;
  localparam logic [2:0] RBACK = 3'd7;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       rd;
    logic       ext;
  } req_t;

  logic [2:0]    state, state_nx;
  req_t          req;
  logic          dir_r, ta, dir_rise, dir_fall;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit, waiting;
  logic          accept, req_ext, bad_addr;
  logic          done_nx, err_nx;
  logic [7:0]    tx_byte;
  logic          rx_en, rx_active_nx;

  logic       busy_q, done_q, err_q, data_vld_q, rx_cmd_vld_q, rx_active_q, rx_end_q;
  logic [7:0] rdata_q, data_q, rx_cmd_q;

  assign ta       = ulpi_dir != dir_r;
  assign dir_rise = ulpi_dir & ~dir_r;
  assign dir_fall = ~ulpi_dir & dir_r;

  assign accept   = (state == IDLE) && !ulpi_dir && (sys.sys_reg_write || sys.sys_reg_read);
  assign req_ext  = sys.sys_reg_addr > 8'h3F;
  assign bad_addr = req_ext && (EXT_REG_EN == 0);

  assign waiting  = state inside {CMD, EXT, WDATA, RTURN, RBACK};
  assign tmo_hit  = tmo_cnt == CW'(TIMEOUT - 1);

  // Link owns the bus only when the PHY has not claimed it and no turnaround is in flight.
  assign ulpi_data = (!ulpi_dir && !ta) ? tx_byte : 8'hzz;

  always_comb begin
    tx_byte = 8'h00;
    case (state)
      CMD:     tx_byte = {1'b1, req.rd, req.ext ? 6'h2F : req.addr[5:0]};
      EXT:     tx_byte = req.addr;
      WDATA:   tx_byte = req.wdata;
      default: tx_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (bad_addr) err_nx = 1'b1;
        else          state_nx = CMD;
      end
      CMD, EXT, WDATA: begin
        if (dir_rise) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else if (ulpi_nxt) begin
          if (state == WDATA)             state_nx = STP;
          else if (state == CMD && req.ext) state_nx = EXT;
          else                            state_nx = req.rd ? RTURN : WDATA;
        end else if (tmo_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      STP: begin
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      RTURN: begin
        if (ulpi_dir) state_nx = RDATA;
        else if (tmo_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      RDATA: state_nx = RBACK;
      RBACK: begin
        if (!ulpi_dir) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else if (tmo_hit) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // The register read-back byte belongs to the engine, not to the RX stream.
  assign rx_en = ulpi_dir && !ta && (state != RDATA);

  always_comb begin
    rx_active_nx = rx_active_q;
    if (dir_fall)                   rx_active_nx = 1'b0;
    else if (dir_rise && ulpi_nxt)  rx_active_nx = 1'b1;
    else if (rx_en && !ulpi_nxt)    rx_active_nx = ulpi_data[4];
  end

  always_ff @(posedge ulpi_clk) begin
    if (sys_reset) begin
      state        <= IDLE;
      req          <= '0;
      dir_r        <= 1'b0;
      tmo_cnt      <= '0;
      ulpi_stp     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 8'h00;
      data_q       <= 8'h00;
      data_vld_q   <= 1'b0;
      rx_cmd_q     <= 8'h00;
      rx_cmd_vld_q <= 1'b0;
      rx_active_q  <= 1'b0;
      rx_end_q     <= 1'b0;
    end else begin
      state <= state_nx;
      dir_r <= ulpi_dir;
      if (accept) begin
        req.addr  <= sys.sys_reg_addr;
        req.wdata <= sys.sys_reg_wdata;
        req.rd    <= !sys.sys_reg_write;
        req.ext   <= req_ext;
      end
      if (state_nx != state) tmo_cnt <= '0;
      else if (waiting)      tmo_cnt <= tmo_cnt + CW'(1);
      ulpi_stp <= state_nx == STP;
      busy_q   <= state_nx != IDLE;
      done_q   <= done_nx;
      err_q    <= err_nx;
      if (state == RDATA) rdata_q <= ulpi_data;
      data_vld_q <= rx_en && ulpi_nxt;
      if (rx_en && ulpi_nxt) data_q <= ulpi_data;
      rx_cmd_vld_q <= rx_en && !ulpi_nxt;
      if (rx_en && !ulpi_nxt) rx_cmd_q <= ulpi_data;
      rx_active_q <= rx_active_nx;
      rx_end_q    <= rx_active_q && !rx_active_nx;
    end
  end

  assign sys.sys_reg_busy     = busy_q;
  assign sys.sys_reg_rdata    = rdata_q;
  assign sys.sys_reg_done     = done_q;
  assign sys.sys_reg_err      = err_q;
  assign sys.sys_data         = data_q;
  assign sys.sys_data_valid   = data_vld_q;
  assign sys.sys_rx_cmd       = rx_cmd_q;
  assign sys.sys_rx_cmd_valid = rx_cmd_vld_q;
  assign sys.sys_rx_active    = rx_active_q;
  assign sys.sys_rx_end       = rx_end_q;
endmodule

// File: tb/tb_ulpi_link.sv
// Bench for ulpi_link: two instances (immediate-only and extended) share one
// PHY model; expected bus bytes and responses come from the protocol rules.
module tb_ulpi_link;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       sys_reset;
  logic       dir, nxt, phy_oe;
  logic [7:0] phy_val;
  wire  [7:0] bus0, bus1;
  logic       stp0, stp1;

  int total = 0, bad = 0;
  int done_cnt = 0, err_cnt = 0, stp_cnt = 0, rxend_cnt = 0, rxcmdv_cnt = 0, act0 = 0;
  logic [7:0] dq[$];
  logic [7:0] pkt[$];

  always #5 clk = ~clk;

  assign bus0 = phy_oe ? phy_val : 8'hzz;
  assign bus1 = phy_oe ? phy_val : 8'hzz;

  ulpi_link_if if0();
  ulpi_link_if if1();

  ulpi_link #(.EXT_REG_EN(0), .TIMEOUT(TMO)) dut (
    .ulpi_clk(clk), .sys_reset(sys_reset), .ulpi_dir(dir), .ulpi_nxt(nxt),
    .ulpi_stp(stp0), .ulpi_data(bus0), .sys(if0)
  );

  ulpi_link #(.EXT_REG_EN(1), .TIMEOUT(TMO)) dut_ext (
    .ulpi_clk(clk), .sys_reset(sys_reset), .ulpi_dir(dir), .ulpi_nxt(nxt),
    .ulpi_stp(stp1), .ulpi_data(bus1), .sys(if1)
  );

  always @(negedge clk) begin
    if (if0.sys_reg_done)     done_cnt++;
    if (if0.sys_reg_err)      err_cnt++;
    if (stp0)                 stp_cnt++;
    if (if0.sys_rx_end)       rxend_cnt++;
    if (if0.sys_rx_cmd_valid) rxcmdv_cnt++;
    if (if0.sys_data_valid)   dq.push_back(if0.sys_data);
    if (!dir && bus0 !== 8'h00) act0++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic logic [7:0] bus_of(input int s);
    return (s != 0) ? bus1 : bus0;
  endfunction
  function automatic logic stp_of(input int s);
    return (s != 0) ? stp1 : stp0;
  endfunction
  function automatic logic busy_of(input int s);
    return (s != 0) ? if1.sys_reg_busy : if0.sys_reg_busy;
  endfunction
  function automatic logic done_of(input int s);
    return (s != 0) ? if1.sys_reg_done : if0.sys_reg_done;
  endfunction

  task automatic drive_req(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    if0.sys_reg_write = w; if0.sys_reg_read = r; if0.sys_reg_addr = a; if0.sys_reg_wdata = d;
    if1.sys_reg_write = w; if1.sys_reg_read = r; if1.sys_reg_addr = a; if1.sys_reg_wdata = d;
  endtask

  // Register write on instance s; PHY accepts each byte after dly idle cycles.
  task automatic reg_write(input int s, input logic [7:0] a, input logic [7:0] d,
                           input int dly, input logic also_read);
    logic [7:0] exp_q[$];
    logic [7:0] cmd;
    if (a > 8'h3F) begin
      exp_q.push_back(8'hAF);
      exp_q.push_back(a);
    end else begin
      cmd = {2'b10, a[5:0]};
      exp_q.push_back(cmd);
    end
    exp_q.push_back(d);
    drive_req(1'b1, also_read, a, d);
    tick();
    drive_req(1'b0, 1'b0, 8'h00, 8'h00);
    chk("wr_busy", busy_of(s), 1);
    foreach (exp_q[i]) begin
      for (int k = 0; k < dly; k++) begin
        chk("wr_hold", bus_of(s), exp_q[i]);
        tick();
      end
      chk("wr_byte", bus_of(s), exp_q[i]);
      chk("wr_nostp", stp_of(s), 0);
      nxt = 1'b1;
      tick();
      nxt = 1'b0;
    end
    chk("wr_stp", stp_of(s), 1);
    chk("wr_stp_bus", bus_of(s), 8'h00);
    tick();
    chk("wr_done", done_of(s), 1);
    chk("wr_idle_busy", busy_of(s), 0);
    chk("wr_stp_off", stp_of(s), 0);
    tick();
    chk("wr_done_once", done_of(s), 0);
  endtask

  task automatic reg_read(input logic [7:0] a, input logic [7:0] rb, input int dly);
    int c0;
    logic [7:0] cmd;
    c0  = rxcmdv_cnt;
    cmd = {2'b11, a[5:0]};
    drive_req(1'b0, 1'b1, a, 8'h00);
    tick();
    drive_req(1'b0, 1'b0, 8'h00, 8'h00);
    chk("rd_busy", if0.sys_reg_busy, 1);
    chk("rd_cmd", bus0, cmd);
    repeat (dly) tick();
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
    chk("rd_turn_bus", bus0, 8'h00);
    repeat (dly) tick();
    dir = 1'b1;
    tick();
    phy_oe = 1'b1; phy_val = rb;
    tick();
    dir = 1'b0; phy_oe = 1'b0;
    tick();
    chk("rd_done", if0.sys_reg_done, 1);
    chk("rd_rdata", if0.sys_reg_rdata, rb);
    chk("rd_busy_off", if0.sys_reg_busy, 0);
    tick();
    chk("rd_done_once", if0.sys_reg_done, 0);
    chk("rd_no_rxcmd", rxcmdv_cnt - c0, 0);
  endtask

  task automatic rx_packet();
    int e0;
    e0 = rxend_cnt;
    dq.delete();
    dir = 1'b1; nxt = 1'b1;
    tick();
    foreach (pkt[i]) begin
      chk("rx_active", if0.sys_rx_active, 1);
      phy_oe = 1'b1; phy_val = pkt[i];
      tick();
    end
    chk("rx_active_last", if0.sys_rx_active, 1);
    dir = 1'b0; nxt = 1'b0; phy_oe = 1'b0;
    tick();
    chk("rx_active_off", if0.sys_rx_active, 0);
    chk("rx_end", if0.sys_rx_end, 1);
    tick();
    chk("rx_end_pulse", if0.sys_rx_end, 0);
    chk("rx_count", dq.size(), pkt.size());
    foreach (pkt[i]) if (i < dq.size()) chk("rx_byte", dq[i], pkt[i]);
    chk("rx_end_once", rxend_cnt - e0, 1);
  endtask

  task automatic abort_wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] rxc);
    int s0, e0;
    s0 = stp_cnt; e0 = err_cnt;
    drive_req(1'b1, 1'b0, a, d);
    tick();
    drive_req(1'b0, 1'b0, 8'h00, 8'h00);
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
    chk("ab_wdata", bus0, d);
    dir = 1'b1;
    tick();
    chk("ab_err", if0.sys_reg_err, 1);
    chk("ab_busy", if0.sys_reg_busy, 0);
    phy_oe = 1'b1; phy_val = rxc;
    tick();
    chk("ab_rxcmd", if0.sys_rx_cmd, rxc);
    chk("ab_rxcmd_vld", if0.sys_rx_cmd_valid, 1);
    dir = 1'b0; phy_oe = 1'b0;
    tick();
    tick();
    chk("ab_no_stp", stp_cnt - s0, 0);
    chk("ab_err_once", err_cnt - e0, 1);
  endtask

  task automatic ext_write(input logic [7:0] a, input logic [7:0] d, input int dly);
    int e0, a0, s0;
    e0 = err_cnt; a0 = act0; s0 = stp_cnt;
    reg_write(1, a, d, dly, 1'b0);
    chk("ext0_err", err_cnt - e0, 1);
    chk("ext0_quiet", act0 - a0, 0);
    chk("ext0_no_stp", stp_cnt - s0, 0);
  endtask

  initial begin
    int d0, e0, op;
    logic [7:0] ra, rd;
    sys_reset = 1'b1; dir = 1'b0; nxt = 1'b0; phy_oe = 1'b0; phy_val = 8'h00;
    drive_req(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) tick();
    chk("rst_stp", stp0, 0);
    chk("rst_busy", if0.sys_reg_busy, 0);
    chk("rst_done_err", {if0.sys_reg_done, if0.sys_reg_err}, 0);
    chk("rst_rdata", if0.sys_reg_rdata, 0);
    chk("rst_rxcmd", {if0.sys_rx_cmd, if0.sys_rx_cmd_valid}, 0);
    chk("rst_data", {if0.sys_data, if0.sys_data_valid}, 0);
    chk("rst_rx", {if0.sys_rx_active, if0.sys_rx_end}, 0);
    chk("rst_bus", bus0, 8'h00);
    sys_reset = 1'b0;
    tick();

    reg_write(0, 8'h16, 8'hA5, 1, 1'b0);
    reg_read(8'h0A, 8'h3C, 0);
    ext_write(8'h85, 8'h11, 1);
    abort_wr(8'h05, 8'h77, 8'h4E);
    pkt = '{8'hC3, 8'h00, 8'h10};
    rx_packet();
    reg_write(0, 8'h21, 8'h5A, 0, 1'b1);

    // Timeout: PHY never asserts nxt
    e0 = err_cnt;
    drive_req(1'b1, 1'b0, 8'h02, 8'h33);
    tick();
    drive_req(1'b0, 1'b0, 8'h00, 8'h00);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      if (k < TMO) chk("tmo_wait", if0.sys_reg_err, 0);
      else         chk("tmo_err", if0.sys_reg_err, 1);
    end
    chk("tmo_busy", if0.sys_reg_busy, 0);
    tick();
    chk("tmo_once", err_cnt - e0, 1);

    // Reset while waiting for the read turnaround
    d0 = done_cnt; e0 = err_cnt;
    drive_req(1'b0, 1'b1, 8'h0B, 8'h00);
    tick();
    drive_req(1'b0, 1'b0, 8'h00, 8'h00);
    nxt = 1'b1;
    tick();
    nxt = 1'b0;
    chk("rst_rturn_busy_pre", if0.sys_reg_busy, 1);
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    chk("rst_rturn_busy", if0.sys_reg_busy, 0);
    chk("rst_rturn_stp", stp0, 0);
    repeat (3) tick();
    chk("rst_rturn_silent", (done_cnt - d0) + (err_cnt - e0), 0);

    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(0, 3);
      rd = 8'($urandom);
      case (op)
        0: begin
          ra = 8'($urandom_range(0, 63));
          reg_write(0, ra, rd, $urandom_range(0, 2), 1'($urandom));
        end
        1: begin
          ra = 8'($urandom_range(0, 63));
          reg_read(ra, rd, $urandom_range(0, 2));
        end
        2: begin
          pkt.delete();
          for (int k = 0; k < $urandom_range(1, 5); k++) pkt.push_back(8'($urandom));
          rx_packet();
        end
        default: begin
          ra = 8'($urandom_range(64, 255));
          ext_write(ra, rd, $urandom_range(0, 2));
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
